pll_step_sequencer: RTL and testbench
=====================================

Name: pll_step_sequencer

Overview:
- Frequency-step controller for the SDRAM tester clock.
- Converts debounced operator buttons, a start-sweep strobe and tester pass/fail status into a ROM index (pos) and sequences the PLL reconfiguration handshake (write_from_rom, reconfig, busy, watchdog reset).
- Sits between the debounce/keyboard front end and the pll_reconfig megafunction.
- Its recfg_active output also holds the tester reset and clears the elapsed-time counters.

Parameters:
- NUM_STEPS, 11: number of frequency ROMs; pos range 0..NUM_STEPS-1 (0 = highest frequency).
- DEFAULT_POS, 7: pos after reset.
- BUSY_TIMEOUT, 1000: watchdog cycles allowed for reconfig completion.
- POS_W, 4: width of pos.

Ports:
- clock_50_i  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous active-high reset.
- btn_up  in  1  debounced level; rising edge selects the next higher frequency.
- btn_down  in  1  debounced level; rising edge selects the next lower frequency.
- btn_auto  in  1  debounced level; rising edge toggles auto sweep.
- start_auto  in  1  level; while high, forces a sweep from pos 0.
- adv_ok  in  1  level; tester reports the current step is evaluated (pass and fail counts both nonzero).
- pll_busy  in  1  busy from pll_reconfig.
- pos  out  POS_W  selected ROM index; drives the ROM mux and the frequency display.
- auto  out  1  auto sweep active.
- recfg_active  out  1  pending | (state != IDLE).
- pll_write_from_rom  out  1  one-cycle pulse.
- pll_reconfig  out  1  one-cycle pulse.
- pll_reconfig_reset  out  1  one-cycle pulse on watchdog expiry.
- done  out  1  one-cycle pulse on any return to IDLE from WAIT_DONE.
- timeout_cnt  out  8  saturating count of watchdog expiries.

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock clock_50_i.
- Reset values:
  - pos = DEFAULT_POS; all other outputs 0; pending = 0; state IDLE.
  - Edge-detect history registers load the current button levels, so a button held through reset does not generate an edge.
  - No reconfiguration is issued after reset.
- Request priority, evaluated every cycle in any state, highest first:
  1. start_auto: pos=0, auto=1, pending=1.
  2. btn_auto edge with auto=1: auto=0, pending=1; pos unchanged (re-run current step).
  3. btn_auto edge with auto=0: pos=0, auto=1, pending=1.
  4. btn_up edge and pos>0: pos-1, auto=0, pending=1.
  5. btn_down edge and pos<NUM_STEPS-1: pos+1, auto=0, pending=1.
  6. Auto advance: auto, adv_ok, state IDLE, !pending and pos<NUM_STEPS-1: pos+1, pending=1.
  - Edges at a range limit are ignored (no pending).
  - Auto at the last step stays at that step with auto=1.
- FSM:
  - IDLE: if pending, clear pending and go to LOAD.
  - LOAD: assert pll_write_from_rom for this cycle only; go to GAP.
  - GAP: one cycle; go to WAIT_IDLE.
  - WAIT_IDLE: when pll_busy=0, assert pll_reconfig for this cycle only, load timer=BUSY_TIMEOUT, go to WAIT_DONE.
  - WAIT_DONE:
    - Decrement timer.
    - If timer==1: pulse pll_reconfig_reset and done, increment timeout_cnt (saturates at 255), go to IDLE.
    - Otherwise, if pll_busy=0 and pll_reconfig was not asserted in the previous cycle: pulse done, go to IDLE.
- A request arriving while not in IDLE updates pos immediately and sets pending. The sequence in flight completes, then a full new sequence runs for the latest pos.
- Latency from a button edge in IDLE: pll_write_from_rom asserts 2 cycles later (pending set, then IDLE→LOAD).
- RESET mid-sequence: immediate return to reset values. No pulses are emitted in the reset cycle.

Optional Feature:
- Macro AUTO_SWEEP_EN.
- Defined: auto sweep behaves as above.
- Undefined:
  - auto is constant 0.
  - btn_auto, start_auto and adv_ok are ignored.
  - Priorities 1–3 and 6 are removed.
  - The FSM and manual stepping are unchanged.

Test Plan:
1. Reset, then btn_down edge → pos 7→8; pll_write_from_rom pulse 2 cycles after the edge; pll_busy held 0 → pll_reconfig pulse, done pulse, recfg_active low afterwards.
2. pos=0 with btn_up edge, and pos=10 with btn_down edge → pos unchanged, no pending, no pll_write_from_rom pulse.
3. pll_busy stuck at 1 after pll_reconfig → pll_reconfig_reset and done pulse exactly BUSY_TIMEOUT-1 cycles after the pll_reconfig pulse; timeout_cnt=1; state IDLE.
4. start_auto pulse, then adv_ok held 1 with pll_busy 0 → pos steps 0,1,…,10, one full sequence each; at pos=10 it stays with auto=1; btn_auto edge → auto=0 and one re-run at pos=10.
5. btn_down edge during WAIT_DONE → pos updates at once; current sequence finishes; a second LOAD follows; recfg_active stays high continuously until the second done.
6. Same-cycle start_auto and btn_down edge → pos=0, auto=1. With AUTO_SWEEP_EN undefined: start_auto is ignored and pos=8.

Source files
------------

// File: rtl/pll_step_sequencer_if.sv
// Operator/tester/PLL-side signal bundle for pll_step_sequencer.
// master: the sequencer itself; slave: front end, tester and pll_reconfig side.
interface pll_step_sequencer_if #(
    parameter int unsigned POS_W = 4
);
    logic             btn_up;
    logic             btn_down;
    logic             btn_auto;
    logic             start_auto;
    logic             adv_ok;
    logic             pll_busy;
    logic [POS_W-1:0] pos;
    logic             auto;
    logic             recfg_active;
    logic             pll_write_from_rom;
    logic             pll_reconfig;
    logic             pll_reconfig_reset;
    logic             done;
    logic [7:0]       timeout_cnt;

    modport master (
        input  btn_up, btn_down, btn_auto, start_auto, adv_ok, pll_busy,
        output pos, auto, recfg_active, pll_write_from_rom, pll_reconfig,
               pll_reconfig_reset, done, timeout_cnt
    );

    modport slave (
        output btn_up, btn_down, btn_auto, start_auto, adv_ok, pll_busy,
        input  pos, auto, recfg_active, pll_write_from_rom, pll_reconfig,
               pll_reconfig_reset, done, timeout_cnt
    );
endinterface

// File: rtl/pll_step_sequencer.sv
// Frequency-step controller: turns button/sweep requests into a ROM index and
// runs the pll_reconfig write/reconfig/busy handshake with a watchdog.
// Optional auto sweep (btn_auto, start_auto, adv_ok) is built only when
// AUTO_SWEEP_EN is defined; otherwise auto is tied low and those inputs are ignored.
module pll_step_sequencer #(
    parameter int unsigned NUM_STEPS    = 11,
    parameter int unsigned DEFAULT_POS  = 7,
    parameter int unsigned BUSY_TIMEOUT = 1000,
    parameter int unsigned POS_W        = 4
) (
    input  logic                  clock_50_i,
    input  logic                  RESET,
    pll_step_sequencer_if.master  bus
);
    localparam int unsigned      TMR_W      = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(NUM_STEPS - 1);
    localparam logic [POS_W-1:0] RESET_POS  = POS_W'(DEFAULT_POS);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(BUSY_TIMEOUT);
    // Watchdog fires when the decremented count reaches 1.
    localparam logic [TMR_W-1:0] TMR_EXPIRE = TMR_W'(2);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP, S_WAIT_IDLE, S_WAIT_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pending_q, pending_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       timeout_cnt_q, timeout_cnt_d;
    logic             wfr_q, wfr_d;
    logic             reconfig_q, reconfig_d;
    logic             rreset_q, rreset_d;
    logic             done_q, done_d;
    logic             recfg_active_q, recfg_active_d;
    logic             up_hist_q, down_hist_q;
    logic             up_edge_c, down_edge_c;

    assign up_edge_c   = bus.btn_up & ~up_hist_q;
    assign down_edge_c = bus.btn_down & ~down_hist_q;

`ifdef AUTO_SWEEP_EN
    logic auto_q, auto_d;
    logic auto_hist_q;
    logic auto_edge_c;

    assign auto_edge_c = bus.btn_auto & ~auto_hist_q;
    assign bus.auto    = auto_q;
`else
    logic unused_c;

    assign unused_c = ^{bus.btn_auto, bus.start_auto, bus.adv_ok};
    assign bus.auto = 1'b0;
`endif

    assign bus.pos                = pos_q;
    assign bus.recfg_active       = recfg_active_q;
    assign bus.pll_write_from_rom = wfr_q;
    assign bus.pll_reconfig       = reconfig_q;
    assign bus.pll_reconfig_reset = rreset_q;
    assign bus.done               = done_q;
    assign bus.timeout_cnt        = timeout_cnt_q;

    // Next-state: handshake FSM first, then request priority (may re-set pending).
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        pending_d     = pending_q;
        timer_d       = timer_q;
        timeout_cnt_d = timeout_cnt_q;
        wfr_d         = 1'b0;
        reconfig_d    = 1'b0;
        rreset_d      = 1'b0;
        done_d        = 1'b0;
`ifdef AUTO_SWEEP_EN
        auto_d        = auto_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    wfr_d     = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD:      state_d = S_GAP;
            S_GAP:       state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: begin
                if (!bus.pll_busy) begin
                    reconfig_d = 1'b1;
                    timer_d    = TMR_LOAD;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_q - TMR_W'(1);
                if (timer_q == TMR_EXPIRE) begin
                    rreset_d = 1'b1;
                    done_d   = 1'b1;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end else if (!bus.pll_busy && !reconfig_q) begin
                    // reconfig_q high means the PLL has only just seen the strobe.
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AUTO_SWEEP_EN
        if (bus.start_auto) begin
            pos_d     = '0;
            auto_d    = 1'b1;
            pending_d = 1'b1;
        end else if (auto_edge_c && auto_q) begin
            auto_d    = 1'b0;
            pending_d = 1'b1;
        end else if (auto_edge_c) begin
            pos_d     = '0;
            auto_d    = 1'b1;
            pending_d = 1'b1;
        end else
`endif
        if (up_edge_c && (pos_q != '0)) begin
            pos_d     = pos_q - POS_W'(1);
            pending_d = 1'b1;
`ifdef AUTO_SWEEP_EN
            auto_d    = 1'b0;
`endif
        end else if (down_edge_c && (pos_q != LAST_POS)) begin
            pos_d     = pos_q + POS_W'(1);
            pending_d = 1'b1;
`ifdef AUTO_SWEEP_EN
            auto_d    = 1'b0;
        end else if (auto_q && bus.adv_ok && (state_q == S_IDLE) && !pending_q
                     && (pos_q != LAST_POS)) begin
            pos_d     = pos_q + POS_W'(1);
            pending_d = 1'b1;
`endif
        end

        recfg_active_d = pending_d | (state_d != S_IDLE);
    end

    // State and output registers; history loads live levels in reset to mask held buttons.
    always_ff @(posedge clock_50_i) begin
        if (RESET) begin
            state_q        <= S_IDLE;
            pos_q          <= RESET_POS;
            pending_q      <= 1'b0;
            timer_q        <= '0;
            timeout_cnt_q  <= '0;
            wfr_q          <= 1'b0;
            reconfig_q     <= 1'b0;
            rreset_q       <= 1'b0;
            done_q         <= 1'b0;
            recfg_active_q <= 1'b0;
            up_hist_q      <= bus.btn_up;
            down_hist_q    <= bus.btn_down;
`ifdef AUTO_SWEEP_EN
            auto_q         <= 1'b0;
            auto_hist_q    <= bus.btn_auto;
`endif
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            pending_q      <= pending_d;
            timer_q        <= timer_d;
            timeout_cnt_q  <= timeout_cnt_d;
            wfr_q          <= wfr_d;
            reconfig_q     <= reconfig_d;
            rreset_q       <= rreset_d;
            done_q         <= done_d;
            recfg_active_q <= recfg_active_d;
            up_hist_q      <= bus.btn_up;
            down_hist_q    <= bus.btn_down;
`ifdef AUTO_SWEEP_EN
            auto_q         <= auto_d;
            auto_hist_q    <= bus.btn_auto;
`endif
        end
    end
endmodule

// File: tb/tb_pll_step_sequencer.sv
// Self-checking bench for pll_step_sequencer: expected ROM indices are queued
// when a request is driven and compared against pos captured at each ROM write.
module tb_pll_step_sequencer;
    localparam int unsigned NUM_STEPS    = 11;
    localparam int unsigned DEFAULT_POS  = 7;
    localparam int unsigned BUSY_TIMEOUT = 1000;
    localparam int unsigned POS_W        = 4;

    localparam int W_WFR = 0, W_RCFG = 1, W_RRST = 2, W_DONE = 3;
    localparam int B_UP = 0, B_DOWN = 1, B_AUTO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    pll_step_sequencer_if #(.POS_W(POS_W)) bus ();

    pll_step_sequencer #(
        .NUM_STEPS(NUM_STEPS), .DEFAULT_POS(DEFAULT_POS),
        .BUSY_TIMEOUT(BUSY_TIMEOUT), .POS_W(POS_W)
    ) dut (
        .clock_50_i(clk),
        .RESET(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int model_pos;
    int exp_q[$];
    int got_q[$];

    // Monitor: counts pulses and records pos at each ROM write, 2 ns after the edge.
    int cyc = 0, n_wfr = 0, n_rcfg = 0, n_rrst = 0, n_done = 0;
    int t_wfr = 0, t_rcfg = 0, t_rrst = 0, t_done = 0;
    always @(posedge clk) begin
        #2;
        cyc++;
        if (bus.pll_write_from_rom === 1'b1) begin n_wfr++; t_wfr = cyc; got_q.push_back(int'(bus.pos)); end
        if (bus.pll_reconfig === 1'b1) begin n_rcfg++; t_rcfg = cyc; end
        if (bus.pll_reconfig_reset === 1'b1) begin n_rrst++; t_rrst = cyc; end
        if (bus.done === 1'b1) begin n_done++; t_done = cyc; end
    end

    function automatic int cnt(input int which);
        case (which)
            W_WFR:   return n_wfr;
            W_RCFG:  return n_rcfg;
            W_RRST:  return n_rrst;
            default: return n_done;
        endcase
    endfunction

    function automatic int pop_q(input bit from_exp);
        if (from_exp) return (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        return (got_q.size() == 0) ? -2 : got_q.pop_front();
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for(input int which, input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (cnt(which) >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_btn(input int which, output int c0);
        @(negedge clk);
        c0 = cyc;
        case (which)
            B_UP:    bus.btn_up   = 1'b1;
            B_DOWN:  bus.btn_down = 1'b1;
            default: bus.btn_auto = 1'b1;
        endcase
        @(negedge clk);
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_auto = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.btn_down = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        checks++; if (int'(bus.pos) !== DEFAULT_POS) begin failures++; $display("FAIL reset_pos: got %0d expected %0d", bus.pos, DEFAULT_POS); end
        checks++; if (bus.recfg_active !== 1'b0) begin failures++; $display("FAIL reset_recfg_held_btn: got %0b expected 0", bus.recfg_active); end
        checks++; if (bus.auto !== 1'b0 || bus.timeout_cnt !== 8'd0) begin failures++; $display("FAIL reset_auto_tcnt: got %0b/%0d expected 0/0", bus.auto, bus.timeout_cnt); end
        checks++; if (n_wfr !== 0 || n_rcfg !== 0 || n_done !== 0) begin failures++; $display("FAIL reset_no_pulses: got wfr=%0d rcfg=%0d done=%0d expected 0", n_wfr, n_rcfg, n_done); end
        bus.btn_down = 1'b0;
        tick(2);
        model_pos = DEFAULT_POS;
    endtask

    task automatic test_step();
        int c0, g, e, r0, d0;
        bit ok;
        r0 = n_rcfg; d0 = n_done;
        model_pos++;
        exp_q.push_back(model_pos);
        pulse_btn(B_DOWN, c0);
        wait_for(W_WFR, n_wfr + 1, ok);
        checks++; if (!ok || (t_wfr - c0) !== 2) begin failures++; $display("FAIL step_latency: got %0d expected 2", t_wfr - c0); end
        g = pop_q(1'b0); e = pop_q(1'b1);
        checks++; if (g !== e) begin failures++; $display("FAIL step_load_pos: got %0d expected %0d", g, e); end
        wait_for(W_DONE, d0 + 1, ok);
        checks++; if (!ok || (t_done - t_rcfg) !== 2) begin failures++; $display("FAIL step_done_after_reconfig: got %0d expected 2", t_done - t_rcfg); end
        checks++; if (n_rcfg !== r0 + 1) begin failures++; $display("FAIL step_reconfig_count: got %0d expected %0d", n_rcfg, r0 + 1); end
        checks++; if (bus.recfg_active !== 1'b0) begin failures++; $display("FAIL step_recfg_low: got %0b expected 0", bus.recfg_active); end
    endtask

    task automatic test_limits();
        int c0, g, e, w0, hi;
        bit ok;
        for (int dir = 0; dir < 2; dir++) begin
            // walk to the limit, one full sequence per step
            while ((dir == 0) ? (model_pos > 0) : (model_pos < NUM_STEPS - 1)) begin
                model_pos = (dir == 0) ? model_pos - 1 : model_pos + 1;
                exp_q.push_back(model_pos);
                w0 = n_wfr;
                pulse_btn((dir == 0) ? B_UP : B_DOWN, c0);
                wait_for(W_WFR, w0 + 1, ok);
                g = pop_q(1'b0); e = pop_q(1'b1);
                checks++; if (!ok || g !== e) begin failures++; $display("FAIL limits_walk_pos: got %0d expected %0d", g, e); end
                wait_for(W_DONE, n_done + 1, ok);
            end
            // push past the limit: nothing may happen
            w0 = n_wfr; hi = 0;
            pulse_btn((dir == 0) ? B_UP : B_DOWN, c0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.recfg_active !== 1'b0) hi++;
            end
            checks++; if (int'(bus.pos) !== model_pos || hi !== 0 || n_wfr !== w0) begin
                failures++; $display("FAIL limits_edge_ignored dir=%0d: got pos=%0d active=%0d loads=%0d expected pos=%0d active=0 loads=%0d", dir, bus.pos, hi, n_wfr, model_pos, w0);
            end
        end
    endtask

    task automatic test_timeout();
        int c0, g, e, d0, r0;
        bit ok;
        d0 = n_done; r0 = n_rcfg;
        model_pos--;
        exp_q.push_back(model_pos);
        pulse_btn(B_UP, c0);
        wait_for(W_WFR, n_wfr + 1, ok);
        g = pop_q(1'b0); e = pop_q(1'b1);
        checks++; if (!ok || g !== e) begin failures++; $display("FAIL timeout_load_pos: got %0d expected %0d", g, e); end
        wait_for(W_RCFG, r0 + 1, ok);
        bus.pll_busy = 1'b1;
        wait_for(W_DONE, d0 + 1, ok);
        checks++; if (!ok || (t_done - t_rcfg) !== BUSY_TIMEOUT - 1) begin failures++; $display("FAIL timeout_delay: got %0d expected %0d", t_done - t_rcfg, BUSY_TIMEOUT - 1); end
        checks++; if (n_rrst !== 1 || t_rrst !== t_done) begin failures++; $display("FAIL timeout_reset_pulse: got count=%0d at %0d expected count=1 at %0d", n_rrst, t_rrst, t_done); end
        checks++; if (bus.timeout_cnt !== 8'd1 || bus.recfg_active !== 1'b0) begin failures++; $display("FAIL timeout_cnt_idle: got cnt=%0d active=%0b expected 1/0", bus.timeout_cnt, bus.recfg_active); end
        bus.pll_busy = 1'b0;
        tick(2);
    endtask

    task automatic test_back_to_back();
        int c0, g, e, d0, w0, drops;
        bit ok;
        d0 = n_done; w0 = n_wfr;
        model_pos++;
        exp_q.push_back(model_pos);
        pulse_btn(B_DOWN, c0);
        wait_for(W_RCFG, n_rcfg + 1, ok);
        bus.pll_busy = 1'b1;
        tick(3);
        model_pos--;
        exp_q.push_back(model_pos);
        pulse_btn(B_UP, c0);
        checks++; if (int'(bus.pos) !== model_pos || n_done !== d0) begin failures++; $display("FAIL b2b_pos_immediate: got pos=%0d done=%0d expected pos=%0d done=%0d", bus.pos, n_done, model_pos, d0); end
        bus.pll_busy = 1'b0;
        drops = 0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_done >= d0 + 2) begin ok = 1'b1; break; end
            if (bus.recfg_active !== 1'b1) drops++;
        end
        checks++; if (!ok || drops !== 0) begin failures++; $display("FAIL b2b_active_continuous: got done_ok=%0b drops=%0d expected 1/0", ok, drops); end
        checks++; if (n_wfr !== w0 + 2) begin failures++; $display("FAIL b2b_two_loads: got %0d expected %0d", n_wfr - w0, 2); end
        for (int k = 0; k < 2; k++) begin
            g = pop_q(1'b0); e = pop_q(1'b1);
            checks++; if (g !== e) begin failures++; $display("FAIL b2b_load_pos%0d: got %0d expected %0d", k, g, e); end
        end
    endtask

    task automatic test_reset_mid();
        int c0, g, e, r0;
        bit ok;
        r0 = n_rcfg;
        exp_q.push_back(model_pos + 1);
        pulse_btn(B_DOWN, c0);
        wait_for(W_WFR, n_wfr + 1, ok);
        g = pop_q(1'b0); e = pop_q(1'b1);
        checks++; if (!ok || g !== e) begin failures++; $display("FAIL rstmid_load_pos: got %0d expected %0d", g, e); end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        checks++; if (int'(bus.pos) !== DEFAULT_POS || bus.recfg_active !== 1'b0 || bus.timeout_cnt !== 8'd0) begin
            failures++; $display("FAIL rstmid_values: got pos=%0d active=%0b tcnt=%0d expected %0d/0/0", bus.pos, bus.recfg_active, bus.timeout_cnt, DEFAULT_POS);
        end
        checks++; if (n_rcfg !== r0) begin failures++; $display("FAIL rstmid_no_reconfig: got %0d expected %0d", n_rcfg, r0); end
        model_pos = DEFAULT_POS;
    endtask

    task automatic test_priority();
        int g, e, exp_auto;
        bit ok;
        @(negedge clk);
        bus.start_auto = 1'b1;
        bus.btn_down   = 1'b1;
        @(negedge clk);
        bus.start_auto = 1'b0;
        bus.btn_down   = 1'b0;
`ifdef AUTO_SWEEP_EN
        model_pos = 0; exp_auto = 1;
`else
        model_pos = model_pos + 1; exp_auto = 0;
`endif
        exp_q.push_back(model_pos);
        checks++; if (int'(bus.pos) !== model_pos || int'(bus.auto) !== exp_auto) begin failures++; $display("FAIL priority_pos_auto: got %0d/%0b expected %0d/%0d", bus.pos, bus.auto, model_pos, exp_auto); end
        wait_for(W_WFR, n_wfr + 1, ok);
        g = pop_q(1'b0); e = pop_q(1'b1);
        checks++; if (!ok || g !== e) begin failures++; $display("FAIL priority_load_pos: got %0d expected %0d", g, e); end
        wait_for(W_DONE, n_done + 1, ok);
        tick(2);
    endtask

`ifdef AUTO_SWEEP_EN
    task automatic test_auto_sweep();
        int c0, g, e, w0, d0;
        bit ok;
        w0 = n_wfr; d0 = n_done;
        @(negedge clk); bus.start_auto = 1'b1;
        @(negedge clk); bus.start_auto = 1'b0; bus.adv_ok = 1'b1;
        for (int p = 0; p < NUM_STEPS; p++) exp_q.push_back(p);
        for (int i = 0; i < NUM_STEPS; i++) begin
            wait_for(W_WFR, w0 + i + 1, ok);
            g = pop_q(1'b0); e = pop_q(1'b1);
            checks++; if (!ok || g !== e) begin failures++; $display("FAIL sweep_step%0d: got %0d expected %0d", i, g, e); end
            wait_for(W_DONE, d0 + i + 1, ok);
        end
        tick(20);
        checks++; if (n_wfr !== w0 + NUM_STEPS || int'(bus.pos) !== NUM_STEPS - 1 || bus.auto !== 1'b1) begin
            failures++; $display("FAIL sweep_hold_last: got loads=%0d pos=%0d auto=%0b expected %0d/%0d/1", n_wfr - w0, bus.pos, bus.auto, NUM_STEPS, NUM_STEPS - 1);
        end
        exp_q.push_back(NUM_STEPS - 1);
        pulse_btn(B_AUTO, c0);
        checks++; if (bus.auto !== 1'b0) begin failures++; $display("FAIL sweep_auto_off: got %0b expected 0", bus.auto); end
        wait_for(W_WFR, w0 + NUM_STEPS + 1, ok);
        g = pop_q(1'b0); e = pop_q(1'b1);
        checks++; if (!ok || g !== e) begin failures++; $display("FAIL sweep_rerun_pos: got %0d expected %0d", g, e); end
        wait_for(W_DONE, d0 + NUM_STEPS + 1, ok);
        tick(10);
        checks++; if (n_wfr !== w0 + NUM_STEPS + 1) begin failures++; $display("FAIL sweep_single_rerun: got %0d expected %0d", n_wfr - w0, NUM_STEPS + 1); end
        bus.adv_ok = 1'b0;
    endtask
`else
    task automatic test_auto_disabled();
        int c0, w0;
        w0 = n_wfr;
        bus.start_auto = 1'b1;
        bus.adv_ok     = 1'b1;
        pulse_btn(B_AUTO, c0);
        tick(10);
        checks++; if (n_wfr !== w0 || int'(bus.pos) !== model_pos || bus.auto !== 1'b0 || bus.recfg_active !== 1'b0) begin
            failures++; $display("FAIL auto_ignored: got loads=%0d pos=%0d auto=%0b active=%0b expected 0/%0d/0/0", n_wfr - w0, bus.pos, bus.auto, bus.recfg_active, model_pos);
        end
        bus.start_auto = 1'b0;
        bus.adv_ok     = 1'b0;
    endtask
`endif

    initial begin
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_auto = 1'b0;
        bus.start_auto = 1'b0; bus.adv_ok = 1'b0; bus.pll_busy = 1'b0;
        test_reset();
        test_step();
        test_limits();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_priority();
`ifdef AUTO_SWEEP_EN
        test_auto_sweep();
`else
        test_auto_disabled();
`endif
        checks++; if (exp_q.size() !== 0 || got_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: got exp=%0d got=%0d expected 0/0", exp_q.size(), got_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
